instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 22 ++
 rtl/instruction_fetch_imm_detect.sv | 19 +
 rtl/instruction_fetch.sv | 107 ++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states,
// two-word instruction encodings and the default reset address.
package instruction_fetch_pkg;

  // Fetch FSM states
  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_IMM = 2'd1,
    PRESENT   = 2'd2
  } fetch_state_t;

  // Low ten bits of an opcode that takes its source from the following word
  localparam logic [9:0]  IMM_SRC_CODE = 10'h3a0;

  // Opcode nibbles whose instructions carry a target/address word
  localparam logic [3:0]  OPC_BRANCH = 4'he;
  localparam logic [3:0]  OPC_FETCH  = 4'hd;

  // Address of the first instruction after reset unless overridden
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

// File: rtl/instruction_fetch_imm_detect.sv
// Classifies an opcode word as one-word or two-word (opcode + immediate).
module imm_detect
  import instruction_fetch_pkg::*;
(
  input  logic [15:0] instr_word,
  output logic        two_word
);

  // Any of the three encodings makes the instruction consume a second word
  always_comb begin
    two_word = 1'b0;
    if ((instr_word[9:0] == IMM_SRC_CODE) ||
        (instr_word[15:12] == OPC_BRANCH) ||
        (instr_word[15:12] == OPC_FETCH)) begin
      two_word = 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: reads one or two words from a combinational
// program ROM, presents a complete instruction to the decoder with a
// valid/ready handshake, and restarts at a new address on redirect.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] ir,
  output logic [15:0] imm,
  output logic        has_imm,
  output logic [15:0] ir_pc,
  output logic        valid,
  input  logic        ready,
  input  logic        redirect,
  input  logic [15:0] redirect_addr
);

  fetch_state_t state_reg, state_next;
  logic [15:0]  pc_reg, pc_next;
  logic [15:0]  ir_reg, ir_next;
  logic [15:0]  imm_reg, imm_next;
  logic         has_imm_reg, has_imm_next;
  logic [15:0]  ir_pc_reg, ir_pc_next;
  logic         two_word;

  imm_detect u_imm_detect (
    .instr_word (rom_data),
    .two_word   (two_word)
  );

  // State and datapath registers; reset wins over redirect and ready
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= FETCH_OP;
      pc_reg      <= RESET_PC;
      ir_reg      <= 16'h0000;
      imm_reg     <= 16'h0000;
      has_imm_reg <= 1'b0;
      ir_pc_reg   <= 16'h0000;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      ir_reg      <= ir_next;
      imm_reg     <= imm_next;
      has_imm_reg <= has_imm_next;
      ir_pc_reg   <= ir_pc_next;
    end
  end

  // Next-state and datapath updates; redirect pre-empts every advance
  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    ir_next      = ir_reg;
    imm_next     = imm_reg;
    has_imm_next = has_imm_reg;
    ir_pc_next   = ir_pc_reg;
    if (redirect) begin
      // A transfer happening this cycle is already complete on the
      // decoder side; anything partially fetched is simply abandoned.
      pc_next    = redirect_addr;
      state_next = FETCH_OP;
    end else begin
      case (state_reg)
        FETCH_OP: begin
          ir_next    = rom_data;
          ir_pc_next = pc_reg;
          pc_next    = pc_reg + 16'd1;
          if (two_word) begin
            state_next = FETCH_IMM;
          end else begin
            imm_next     = 16'h0000;
            has_imm_next = 1'b0;
            state_next   = PRESENT;
          end
        end
        FETCH_IMM: begin
          imm_next     = rom_data;
          has_imm_next = 1'b1;
          pc_next      = pc_reg + 16'd1;
          state_next   = PRESENT;
        end
        PRESENT: begin
          if (ready) begin
            state_next = FETCH_OP;
          end
        end
        default: begin
          state_next = FETCH_OP;
        end
      endcase
    end
  end

  assign rom_addr = pc_reg;
  assign ir       = ir_reg;
  assign imm      = imm_reg;
  assign has_imm  = has_imm_reg;
  assign ir_pc    = ir_pc_reg;
  assign valid    = (state_reg == PRESENT);

endmodule
